// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to active-low seven-segment glyph {dp,g,f,e,d,c,b,a}; dp is always off here.
module seven_segment (
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        unique case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed scan controller for a common-anode seven-segment display with frame-aligned loads.
// Define SEVEN_SEGMENT_SCANNER_LZB_EN to enable leading-zero blanking.
module seven_segment_scanner
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned ON_CYCLES    = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    if (NUM_DIGITS < 2) begin : g_bad_digits
        $error("NUM_DIGITS must be at least 2");
    end
    if (ON_CYCLES < 1) begin : g_bad_on
        $error("ON_CYCLES must be at least 1");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("BLANK_CYCLES must be at least 1");
    end

    logic [4*NUM_DIGITS-1:0] stg_val, val_q;
    logic [NUM_DIGITS-1:0]   stg_dp, stg_en, dp_q, en_q;
    logic                    pending;

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    logic [7:0]            dec_seg;
    logic [NUM_DIGITS-1:0] hi_zero;
    logic                  lz_blank;
    logic                  digit_on;
    logic [NUM_DIGITS-1:0] an_d;
    logic [7:0]            seg_d;

    seven_segment u_decoder (
        .hex (val_q[{idx_q, 2'b00} +: 4]),
        .seg (dec_seg)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        wrap    = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // hi_zero[i]: nibbles i..NUM_DIGITS-1 of the shadow value are all zero.
    always_comb begin
        hi_zero = '0;
        hi_zero[NUM_DIGITS-1] = (val_q[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            hi_zero[i] = hi_zero[i+1] & (val_q[4*i +: 4] == 4'h0);
        end
    end

`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
    assign lz_blank = (idx_q != '0) && hi_zero[idx_q];
`else
    assign lz_blank = 1'b0;
`endif

    assign digit_on = en_q[idx_q] & ~lz_blank;

    // Outputs are computed from the next state so they move on the transition edge.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (state_d == SHOW && digit_on) begin
            an_d  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
            seg_d = {~dp_q[idx_q], dec_seg[6:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            an          <= '1;
            seg         <= SEG_OFF;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            an          <= an_d;
            seg         <= seg_d;
            load_ack    <= wrap & pending;
            frame_start <= wrap;
        end
    end

    // A load on the wrap edge refills staging after the old contents are committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_val <= '0;
            stg_dp  <= '0;
            stg_en  <= '0;
            pending <= 1'b0;
            val_q   <= '0;
            dp_q    <= '0;
            en_q    <= '0;
        end else begin
            if (load) begin
                stg_val <= value_in;
                stg_dp  <= dp_in;
                stg_en  <= en_in;
            end
            if (wrap && pending) begin
                val_q <= stg_val;
                dp_q  <= stg_dp;
                en_q  <= stg_en;
            end
            pending <= load | (pending & ~wrap);
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner with a 4-digit, 5-cycle-slot configuration.
module tb_seven_segment_scanner;

    localparam int ND    = 4;
    localparam int FRAME = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        load;
    logic        load_ack;
    logic        frame_start;
    logic [3:0]  an;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .NUM_DIGITS   (ND),
        .ON_CYCLES    (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .load        (load),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .an          (an),
        .seg         (seg)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Active-low {g,f,e,d,c,b,a} glyphs.
    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latest staged data replaces any earlier expectation.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
        logic       lit;
        logic [3:0] onehot;
        exp_t       e;
        sb_q.delete();
        for (int d = 0; d < ND; d++) begin
            lit = en[d];
`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
            if (d >= 1 && (v >> (4 * d)) == 16'h0) lit = 1'b0;
`endif
            onehot = 4'b0001 << d;
            e.an  = 4'hF;
            e.seg = 8'hFF;
            sb_q.push_back(e);
            if (lit) begin
                e.an  = ~onehot;
                e.seg = {~dp[d], hex_glyph(v[4*d +: 4])};
            end
            for (int k = 0; k < 4; k++) sb_q.push_back(e);
        end
    endtask

    task automatic load_data(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
        value_in = v;
        dp_in    = dp;
        en_in    = en;
        load     = 1'b1;
        push_frame(v, dp, en);
        tick();
        load = 1'b0;
    endtask

    task automatic sync_frame(input string tag);
        int n = 0;
        while (frame_start !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_sync"}, 32'(frame_start), 32'd1);
    endtask

    task automatic wait_ack(input string tag, output int n);
        n = 0;
        while (load_ack !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_ack_seen"}, 32'(load_ack), 32'd1);
    endtask

    // Entered at the sample right after a wrap edge carrying load_ack.
    task automatic compare_frame(input string tag);
        exp_t e;
        for (int i = 0; i < FRAME; i++) begin
            if (sb_q.size() == 0) begin
                check($sformatf("%s_sb_empty%0d", tag, i), 32'd0, 32'd1);
                e = '0;
            end else begin
                e = sb_q.pop_front();
            end
            check($sformatf("%s_an%0d", tag, i), 32'(an), 32'(e.an));
            check($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(e.seg));
            check($sformatf("%s_ack%0d", tag, i), 32'(load_ack), 32'(i == 0));
            check($sformatf("%s_fs%0d", tag, i), 32'(frame_start), 32'(i == 0));
            tick();
        end
        check({tag, "_fs_period"}, 32'(frame_start), 32'd1);
        check({tag, "_single_ack"}, 32'(load_ack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;

        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        en_in    = '0;
        repeat (3) tick();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_ack", 32'(load_ack), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        rst_n = 1'b1;

        n = 0;
        while (frame_start !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("first_fs_latency", 32'(n), 32'd20);
        check("dark_an", 32'(an), 32'hF);

        // Load and scan order.
        load_data(16'h12AF, 4'b0010, 4'hF);
        wait_ack("t2", n);
        check("t2_latency", 32'(n), 32'd19);
        compare_frame("t2");

        // Repeated loads within one frame: last write wins, one ack.
        load_data(16'h1111, 4'b0000, 4'hF);
        tick();
        tick();
        load_data(16'h2222, 4'b0000, 4'hF);
        wait_ack("t3", n);
        check("t3_latency", 32'(n), 32'd16);
        compare_frame("t3");

        // Enable mask.
        load_data(16'h5678, 4'b0000, 4'b0101);
        wait_ack("t4", n);
        compare_frame("t4");

        // Leading zeros.
        load_data(16'h0030, 4'b0000, 4'hF);
        wait_ack("t5", n);
        compare_frame("t5");

        // Load on the wrap edge.
        sync_frame("t6");
        repeat (19) tick();
        load_data(16'h9876, 4'b0000, 4'hF);
        check("t6_wrap_fs", 32'(frame_start), 32'd1);
        check("t6_no_ack_on_wrap", 32'(load_ack), 32'd0);
        wait_ack("t6", n);
        check("t6_latency", 32'(n), 32'd20);
        compare_frame("t6");

        // Reset mid-SHOW with a pending load.
        tick();
        tick();
        check("t1_lit_an", 32'(an), 32'hE);
        check("t1_lit_seg", 32'(seg), 32'h82);
        value_in = 16'hFFFF;
        load     = 1'b1;
        tick();
        load  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t1_async_an", 32'(an), 32'hF);
        check("t1_async_seg", 32'(seg), 32'hFF);
        check("t1_async_ack", 32'(load_ack), 32'd0);
        check("t1_async_fs", 32'(frame_start), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n    = 0;
        acks = 0;
        while (frame_start !== 1'b1 && n < 60) begin
            tick();
            n++;
            if (load_ack === 1'b1) acks++;
        end
        check("t1_fs_latency", 32'(n), 32'd20);
        check("t1_pending_dropped", 32'(acks), 32'd0);
        tick();
        tick();
        check("t1_dark_after", 32'(an), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
